rx_packet_decoder: RTL and testbench
====================================

# rx_packet_decoder

Byte-level packet decoder between the UART receiver and `command_block`. It classifies each received byte as a command header or a vector-write header. Command payload bits and a `flag_command` strobe go to `command_block`. Vector-write payload bytes stream into a BRAM write port, and `flag_write` is pulsed so downstream logic can blank the screen during the transfer.

## Interface
- `VEC_LEN`, 1024: number of data bytes following a write header.
- `ADDR_WIDTH`, 10: BRAM address width; VEC_LEN ≤ 2**ADDR_WIDTH.
- `TIMEOUT_CYCLES`, 1_000_000: idle clock cycles tolerated between data bytes before a write is aborted.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_byte`  in  8  received UART byte; valid only when `rx_ready`.
- `rx_ready`  in  1  one-cycle strobe, one per received byte.
- `rx_data`  out  3  command payload (header bits [2:0]) to `command_block`.
- `flag_command`  out  1  one-cycle strobe: command header accepted.
- `flag_write`  out  1  one-cycle strobe: write header accepted.
- `bram_we`  out  1  BRAM write enable, one cycle per data byte.
- `bram_addr`  out  ADDR_WIDTH  BRAM write address.
- `bram_wdata`  out  8  BRAM write data.
- `bram_wsel`  out  1  target BRAM of the current write (header bit 2).
- `write_done`  out  1  one-cycle strobe: last data byte written.
- `error`  out  1  one-cycle strobe: illegal header or timeout abort.

## Operation
- Header decode uses `rx_byte[7:6]`:
  - 2'b01 = command.
  - 2'b10 = vector write.
  - 2'b00 / 2'b11 = illegal.
- States: IDLE, WRITE.
- IDLE, command header:
  - `rx_data` ← `rx_byte[2:0]`; `flag_command` pulses.
  - Stay in IDLE.
- IDLE, write header:
  - `bram_wsel` ← `rx_byte[2]`; `flag_write` pulses.
  - Byte counter ← 0; timeout counter ← 0; go to WRITE.
- IDLE, illegal header: `error` pulses; stay in IDLE.
- WRITE, on each `rx_ready`:
  - `bram_we`=1, `bram_addr`=byte counter, `bram_wdata`=`rx_byte`.
  - Byte counter increments; timeout counter clears.
  - Bytes received in WRITE are data, never headers, regardless of value.
- WRITE, last byte (counter = VEC_LEN-1): `write_done` pulses in the same cycle as its `bram_we`; return to IDLE.
- WRITE, no byte: timeout counter increments. When it reaches TIMEOUT_CYCLES-1 with no `rx_ready`:
  - `error` pulses; return to IDLE.
  - The partial write is not rolled back.
- Simultaneous `rx_ready` and timeout expiry: the byte wins (written, counter cleared, no error).
- Byte counter width is ADDR_WIDTH+1, so reaching VEC_LEN = 2**ADDR_WIDTH is exact with no wrap.
- `bram_wsel` and `rx_data` hold their values until the next respective header.

## Timing
- All outputs registered.
- Reset values:
  - Every output is 0.
  - State = IDLE; both counters = 0.
- `rx_ready` in cycle N produces its response in cycle N+1:
  - `flag_command`, `flag_write`, `bram_we`, `write_done` and `error` strobes.
  - `rx_data` is valid in the same cycle as `flag_command`.
  - `bram_addr` and `bram_wdata` are valid in the same cycle as `bram_we`.
- A write header followed by a data byte in the very next cycle is legal: first `bram_we` is at N+2 after the header at N.
- Strobes are exactly one cycle and never repeat without a new `rx_ready`, except the timeout `error`.
- `rst` asserted mid-WRITE:
  - Next cycle is IDLE with all outputs 0.
  - A `rx_ready` in the reset cycle is dropped.
  - The next byte after reset deasserts is decoded as a header.
- Throughput: one byte per cycle sustained; no backpressure.

## Test plan
- Reset, then byte 0x45 (cmd) → next cycle `flag_command`=1, `rx_data`=3'b101; one cycle later `flag_command`=0, `rx_data` still 3'b101.
- Byte 0x84, then VEC_LEN bytes valued i[7:0] (i=0..1023), back-to-back:
  - `flag_write` pulses once; `bram_wsel`=1.
  - 1024 `bram_we` pulses at addr i with data i[7:0].
  - `write_done` coincides with addr 1023; state returns to IDLE.
- Byte 0xC0 in IDLE → `error` pulse, no other strobe. Then 0x41 → `flag_command`, `rx_data`=3'b001.
- TIMEOUT_CYCLES=16:
  - Write header, 3 data bytes, then silence → `error` pulses 16 cycles after the last byte; next byte 0x42 decoded as a command.
  - Repeat with a byte arriving in the expiry cycle → that byte is written, no `error`.
- Within a write, a data byte of 0x41 → written to BRAM; no `flag_command`.
- `rst` asserted after 10 data bytes → outputs 0 next cycle. Subsequent 0x81 + VEC_LEN bytes → write restarts at addr 0 with `bram_wsel`=0.

Source files
------------

// File: rtl/rx_packet_decoder_if.sv
// rx_packet_decoder_if: UART byte input and decoded command/BRAM-write outputs of rx_packet_decoder
interface rx_packet_decoder_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_byte;
    logic                  rx_ready;
    logic [2:0]            rx_data;
    logic                  flag_command;
    logic                  flag_write;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [7:0]            bram_wdata;
    logic                  bram_wsel;
    logic                  write_done;
    logic                  error;
    modport master (
        output rx_byte, rx_ready,
        input  rx_data, flag_command, flag_write, bram_we, bram_addr, bram_wdata, bram_wsel, write_done, error
    );
    modport slave (
        input  rx_byte, rx_ready,
        output rx_data, flag_command, flag_write, bram_we, bram_addr, bram_wdata, bram_wsel, write_done, error
    );
endinterface

// File: rtl/rx_packet_decoder.sv
// rx_packet_decoder: classifies UART bytes as command or vector-write headers and streams write payloads into BRAM
module rx_packet_decoder #(
    parameter int VEC_LEN        = 1024,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic                clk,
    input logic                rst,
    rx_packet_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;
    localparam logic [ADDR_WIDTH:0] LAST_BYTE = (ADDR_WIDTH + 1)'(VEC_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [2:0]            rx_data_q, rx_data_d;
    logic                  wsel_q, wsel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  fcmd_q, fcmd_d;
    logic                  fwr_q, fwr_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  hdr_cmd, hdr_wr;
    assign hdr_cmd = bus.rx_byte[7:6] == 2'b01;
    assign hdr_wr  = bus.rx_byte[7:6] == 2'b10;
    // Next-state: header decode in IDLE, payload streaming with idle timeout in WRITE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        rx_data_d = rx_data_q;
        wsel_d    = wsel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fcmd_d    = 1'b0;
        fwr_d     = 1'b0;
        we_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (state_q == IDLE) begin
            if (bus.rx_ready) begin
                if (hdr_cmd) begin
                    rx_data_d = bus.rx_byte[2:0];
                    fcmd_d    = 1'b1;
                end else if (hdr_wr) begin
                    wsel_d  = bus.rx_byte[2];
                    fwr_d   = 1'b1;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = WRITE;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (bus.rx_ready) begin
            // A byte always beats a coinciding timeout expiry
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_WIDTH-1:0];
            wdata_d = bus.rx_byte;
            cnt_d   = cnt_q + 1'b1;
            tmo_d   = '0;
            if (cnt_q == LAST_BYTE) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            tmo_d   = '0;
            state_d = IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end
    // State and registered outputs; reset drops any byte presented in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            rx_data_q <= '0;
            wsel_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            fcmd_q    <= 1'b0;
            fwr_q     <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            rx_data_q <= rx_data_d;
            wsel_q    <= wsel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            fcmd_q    <= fcmd_d;
            fwr_q     <= fwr_d;
            we_q      <= we_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
    assign bus.rx_data      = rx_data_q;
    assign bus.flag_command = fcmd_q;
    assign bus.flag_write   = fwr_q;
    assign bus.bram_we      = we_q;
    assign bus.bram_addr    = addr_q;
    assign bus.bram_wdata   = wdata_q;
    assign bus.bram_wsel    = wsel_q;
    assign bus.write_done   = done_q;
    assign bus.error        = err_q;
endmodule

// File: tb/tb_rx_packet_decoder.sv
// tb_rx_packet_decoder: directed checks of header decode, BRAM streaming, timeout and mid-write reset
module tb_rx_packet_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    rx_packet_decoder_if #(.ADDR_WIDTH(10)) bus ();
    rx_packet_decoder #(.VEC_LEN(1024), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    // Strobes packed as {flag_command, flag_write, bram_we, write_done, error}
    function automatic logic [4:0] stb();
        return {bus.flag_command, bus.flag_write, bus.bram_we, bus.write_done, bus.error};
    endfunction
    // Present a byte (or idle) for one cycle; on return the registered response is visible
    task automatic drive(input logic r, input logic [7:0] b);
        bus.rx_ready = r;
        bus.rx_byte  = b;
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        bus.rx_ready = 1'b0;
        bus.rx_byte  = 8'h00;
        @(negedge clk);
        drive(0, 8'h00);
        drive(0, 8'h00);
        chk("rst_strobes", 32'(stb()), 32'h0);
        chk("rst_data", {bus.rx_data, bus.bram_wsel, bus.bram_addr, bus.bram_wdata}, 32'h0);
        rst = 1'b0;
        drive(1, 8'h45);
        chk("cmd45_stb", 32'(stb()), 32'b10000);
        chk("cmd45_data", 32'(bus.rx_data), 32'd5);
        drive(0, 8'h00);
        chk("cmd45_off", 32'(stb()), 32'h0);
        chk("cmd45_hold", 32'(bus.rx_data), 32'd5);
        drive(1, 8'h84);
        chk("wr84_stb", 32'(stb()), 32'b01000);
        chk("wr84_wsel", 32'(bus.bram_wsel), 32'd1);
        for (int i = 0; i < 1024; i++) begin
            drive(1, 8'(i));
            chk("wr84_byte", {9'd0, stb(), bus.bram_addr, bus.bram_wdata},
                {9'd0, 3'b001, i == 1023, 1'b0, 10'(i), 8'(i)});
        end
        drive(0, 8'h00);
        chk("wr84_end", 32'(stb()), 32'h0);
        drive(1, 8'hC0);
        chk("illegal_c0", 32'(stb()), 32'b00001);
        drive(1, 8'h41);
        chk("cmd41_stb", 32'(stb()), 32'b10000);
        chk("cmd41_data", {bus.rx_data, bus.bram_wsel}, {3'b001, 1'b1});
        drive(1, 8'h80);
        chk("tmo1_hdr", {27'd0, stb(), bus.bram_wsel}, {27'd0, 5'b01000, 1'b0});
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h10 + 8'(i));
            chk("tmo1_byte", {9'd0, stb(), bus.bram_addr, bus.bram_wdata},
                {9'd0, 5'b00100, 10'(i), 8'h10 + 8'(i)});
        end
        for (int k = 1; k <= 16; k++) begin
            drive(0, 8'h00);
            chk("tmo1_idle", 32'(stb()), k == 16 ? 32'b00001 : 32'h0);
        end
        drive(0, 8'h00);
        chk("tmo1_after", 32'(stb()), 32'h0);
        drive(1, 8'h42);
        chk("tmo1_cmd", {24'd0, stb(), bus.rx_data}, {24'd0, 5'b10000, 3'b010});
        drive(1, 8'h80);
        chk("tmo2_hdr", 32'(stb()), 32'b01000);
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h20 + 8'(i));
            chk("tmo2_byte", {9'd0, stb(), bus.bram_addr, bus.bram_wdata},
                {9'd0, 5'b00100, 10'(i), 8'h20 + 8'(i)});
        end
        for (int k = 1; k <= 15; k++) begin
            drive(0, 8'h00);
            chk("tmo2_idle", 32'(stb()), 32'h0);
        end
        drive(1, 8'hAA);
        chk("tmo2_race", {9'd0, stb(), bus.bram_addr, bus.bram_wdata}, {9'd0, 5'b00100, 10'd3, 8'hAA});
        drive(1, 8'h41);
        chk("data41", {6'd0, stb(), bus.rx_data, bus.bram_addr, bus.bram_wdata},
            {6'd0, 5'b00100, 3'b010, 10'd4, 8'h41});
        for (int k = 1; k <= 16; k++) begin
            drive(0, 8'h00);
            chk("tmo3_idle", 32'(stb()), k == 16 ? 32'b00001 : 32'h0);
        end
        drive(1, 8'h84);
        chk("rst_hdr", 32'(stb()), 32'b01000);
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'h50 + 8'(i));
            chk("rst_byte", {9'd0, stb(), bus.bram_addr, bus.bram_wdata},
                {9'd0, 5'b00100, 10'(i), 8'h50 + 8'(i)});
        end
        rst = 1'b1;
        drive(1, 8'h41);
        chk("midrst_stb", 32'(stb()), 32'h0);
        chk("midrst_data", {bus.rx_data, bus.bram_wsel, bus.bram_addr, bus.bram_wdata}, 32'h0);
        rst = 1'b0;
        drive(1, 8'h81);
        chk("rw_hdr", {26'd0, stb(), bus.bram_wsel}, {26'd0, 5'b01000, 1'b0});
        for (int i = 0; i < 1024; i++) begin
            drive(1, ~8'(i));
            chk("rw_byte", {9'd0, stb(), bus.bram_addr, bus.bram_wdata},
                {9'd0, 3'b001, i == 1023, 1'b0, 10'(i), ~8'(i)});
        end
        drive(1, 8'h43);
        chk("rw_idle_cmd", {24'd0, stb(), bus.rx_data}, {24'd0, 5'b10000, 3'b011});
        drive(0, 8'h00);
        chk("rw_quiet", 32'(stb()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
